// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use and multi-cycle stalls, exception flush,
// multi-cycle timeout and a saturating stalled-cycle counter.
module pipe_ctrl #(
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_r1_en,
  input  logic        id_r2_en,
  input  logic [4:0]  id_r1_addr,
  input  logic [4:0]  id_r2_addr,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_mc_start,
  input  logic        ex_mc_done,
  input  logic        mem_stallreq,
  input  logic        excp_req,
  input  logic [31:0] excp_vector,
  input  logic        id_jump_en,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        jump_ok,
  output logic        mc_abort,
  output logic        mc_timeout,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StMcWait, StFlush} state_e;

  localparam logic [7:0] WaitLast = 8'(MC_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] vec_q, vec_d;
  logic [15:0] cnt_q;

  logic        load_use;
  logic [5:0]  stall_c;
  logic        flush_c;
  logic [31:0] flush_pc_c;
  logic        abort_c;
  logic        timeout_c;

  assign load_use = ex_is_load && (ex_waddr != 5'd0) &&
                    ((id_r1_en && (id_r1_addr == ex_waddr)) ||
                     (id_r2_en && (id_r2_addr == ex_waddr)));

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    vec_d      = vec_q;
    stall_c    = 6'b000000;
    flush_c    = 1'b0;
    flush_pc_c = 32'h0;
    abort_c    = 1'b0;
    timeout_c  = 1'b0;

    if (excp_req) begin
      vec_d = excp_vector;
    end

    if (excp_req) begin
      stall_c = 6'b111111;
    end else if (state_q == StFlush) begin
      stall_c = 6'b000000;
    end else if (mem_stallreq) begin
      stall_c = 6'b011111;
    end else if (((state_q == StMcWait) && !ex_mc_done) ||
                 ((state_q == StRun) && ex_mc_start)) begin
      stall_c = 6'b001111;
    end else if (load_use) begin
      stall_c = 6'b000111;
    end

    case (state_q)
      StRun: begin
        // Held at zero so the count always starts fresh on entry to MC_WAIT.
        wait_d = 8'd0;
        if (excp_req) begin
          state_d = StFlush;
        end else if (ex_mc_start) begin
          state_d = StMcWait;
        end
      end
      StMcWait: begin
        wait_d = wait_q + 8'd1;
        if (excp_req) begin
          state_d = StFlush;
          abort_c = 1'b1;
        end else if (ex_mc_done) begin
          state_d = StRun;
        end else if (wait_q == WaitLast) begin
          state_d   = StRun;
          timeout_c = 1'b1;
        end
      end
      StFlush: begin
        wait_d     = 8'd0;
        flush_c    = 1'b1;
        flush_pc_c = vec_q;
        if (!excp_req) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d = StRun;
        wait_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      wait_q  <= 8'd0;
      vec_q   <= 32'h0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      vec_q   <= vec_d;
      if (stall_c[0] && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign stall      = rst ? 6'b000000 : stall_c;
  assign flush      = rst ? 1'b0 : flush_c;
  assign flush_pc   = rst ? 32'h0 : flush_pc_c;
  assign jump_ok    = rst ? 1'b0 : (id_jump_en && !stall_c[2] && !flush_c);
  assign mc_abort   = rst ? 1'b0 : abort_c;
  assign mc_timeout = rst ? 1'b0 : timeout_c;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected outputs per cycle, a negedge
// monitor pops and compares. A second instance with MC_TIMEOUT=4 covers the timeout path.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_r1_en, id_r2_en;
  logic [4:0]  id_r1_addr, id_r2_addr;
  logic        ex_is_load;
  logic [4:0]  ex_waddr;
  logic        ex_mc_start, ex_mc_done;
  logic        mem_stallreq;
  logic        excp_req;
  logic [31:0] excp_vector;
  logic        id_jump_en;

  logic [5:0]  stall0, stall1;
  logic        flush0, flush1;
  logic [31:0] fpc0, fpc1;
  logic        jok0, jok1;
  logic        abort0, abort1;
  logic        tmo0, tmo1;
  logic [15:0] cnt0, cnt1;

  pipe_ctrl #(.MC_TIMEOUT(64)) u_dut0 (
    .clk(clk), .rst(rst),
    .id_r1_en(id_r1_en), .id_r2_en(id_r2_en),
    .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
    .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .mem_stallreq(mem_stallreq), .excp_req(excp_req), .excp_vector(excp_vector),
    .id_jump_en(id_jump_en),
    .stall(stall0), .flush(flush0), .flush_pc(fpc0), .jump_ok(jok0),
    .mc_abort(abort0), .mc_timeout(tmo0), .stall_cnt(cnt0)
  );

  pipe_ctrl #(.MC_TIMEOUT(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .id_r1_en(id_r1_en), .id_r2_en(id_r2_en),
    .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
    .ex_is_load(ex_is_load), .ex_waddr(ex_waddr),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .mem_stallreq(mem_stallreq), .excp_req(excp_req), .excp_vector(excp_vector),
    .id_jump_en(id_jump_en),
    .stall(stall1), .flush(flush1), .flush_pc(fpc1), .jump_ok(jok1),
    .mc_abort(abort1), .mc_timeout(tmo1), .stall_cnt(cnt1)
  );

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] fpc;
    logic        jok;
    logic        abrt;
    logic        tmo;
    logic        chk_cnt;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t e);
    logic [5:0]  s;
    logic        f, j, a, t;
    logic [31:0] p;
    logic [15:0] c;
    if (e.dut == 0) begin
      s = stall0; f = flush0; p = fpc0; j = jok0; a = abort0; t = tmo0; c = cnt0;
    end else begin
      s = stall1; f = flush1; p = fpc1; j = jok1; a = abort1; t = tmo1; c = cnt1;
    end
    total++;
    if (s !== e.stall || f !== e.flush || p !== e.fpc || j !== e.jok || a !== e.abrt ||
        t !== e.tmo || (e.chk_cnt && c !== e.cnt)) begin
      bad++;
      $display("FAIL %s dut%0d: got stall=%b flush=%b fpc=%h jok=%b abort=%b tmo=%b cnt=%h; want stall=%b flush=%b fpc=%h jok=%b abort=%b tmo=%b cnt=%h(chk=%b)",
               e.name, e.dut, s, f, p, j, a, t, c,
               e.stall, e.flush, e.fpc, e.jok, e.abrt, e.tmo, e.cnt, e.chk_cnt);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      check(sb.pop_front());
    end
  end

  task automatic push(input int dut, input string name, input logic [5:0] st, input logic fl,
                      input logic [31:0] fp, input logic jk, input logic ab, input logic tm,
                      input logic cc, input logic [15:0] cn);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.name = name; e.stall = st; e.flush = fl; e.fpc = fp;
    e.jok = jk; e.abrt = ab; e.tmo = tm; e.chk_cnt = cc; e.cnt = cn;
    sb.push_back(e);
  endtask

  task automatic idle();
    id_r1_en = 0; id_r2_en = 0; id_r1_addr = 0; id_r2_addr = 0;
    ex_is_load = 0; ex_waddr = 0; ex_mc_start = 0; ex_mc_done = 0;
    mem_stallreq = 0; excp_req = 0; excp_vector = 0; id_jump_en = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    idle();
    // Inputs active during reset must not leak to outputs.
    next_cycle();
    id_jump_en = 1; excp_req = 1; excp_vector = 32'h1234_5678; mem_stallreq = 1;
    push(0, "reset", 6'b0, 0, 32'h0, 0, 0, 0, 1, 16'h0);
    next_cycle();
    rst = 1'b0;
    idle();
    push(0, "run_idle", 6'b0, 0, 32'h0, 0, 0, 0, 1, 16'h0);

    // Load-use hazards
    next_cycle(); idle();
    ex_is_load = 1; ex_waddr = 5; id_r1_en = 1; id_r1_addr = 5; id_jump_en = 1;
    push(0, "lu_r1", 6'b000111, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    next_cycle();
    ex_waddr = 0; id_r1_addr = 0;
    push(0, "lu_x0", 6'b000000, 0, 32'h0, 1, 0, 0, 1, 16'h1);
    next_cycle(); idle();
    ex_is_load = 1; ex_waddr = 7; id_r2_en = 1; id_r2_addr = 7;
    push(0, "lu_r2", 6'b000111, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    next_cycle(); idle();
    ex_is_load = 1; ex_waddr = 9; id_r1_addr = 9; id_r2_en = 1; id_r2_addr = 3;
    push(0, "lu_r1_dis", 6'b000000, 0, 32'h0, 0, 0, 0, 1, 16'h2);
    next_cycle(); idle();
    ex_is_load = 1; ex_waddr = 5; id_r1_en = 1; id_r1_addr = 5; mem_stallreq = 1;
    id_jump_en = 1;
    push(0, "mem_over_lu", 6'b011111, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    next_cycle(); idle();
    push(0, "cnt3", 6'b0, 0, 32'h0, 0, 0, 0, 1, 16'h3);

    // Multi-cycle: start at N, done at N+10; mem stall mid-wait
    next_cycle(); idle();
    ex_mc_start = 1;
    push(0, "mc_start", 6'b001111, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 9; i++) begin
      next_cycle(); idle();
      mem_stallreq = (i == 5);
      push(0, "mc_wait", (i == 5) ? 6'b011111 : 6'b001111, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    end
    next_cycle(); idle();
    ex_mc_done = 1;
    push(0, "mc_done", 6'b0, 0, 32'h0, 0, 0, 0, 1, 16'd13);
    next_cycle(); idle();
    push(0, "mc_after", 6'b0, 0, 32'h0, 0, 0, 0, 1, 16'd13);

    // Timeout on the MC_TIMEOUT=4 instance
    next_cycle(); idle();
    ex_mc_start = 1;
    push(1, "tmo_start", 6'b001111, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    for (int i = 1; i <= 4; i++) begin
      next_cycle(); idle();
      push(1, "tmo_wait", 6'b001111, 0, 32'h0, 0, 0, (i == 4), 0, 16'h0);
      push(0, "no_tmo", 6'b001111, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    end
    next_cycle(); idle();
    ex_mc_done = 1;
    push(1, "tmo_after", 6'b0, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    push(0, "dut0_done", 6'b0, 0, 32'h0, 0, 0, 0, 0, 16'h0);

    // Exception during MC_WAIT
    next_cycle(); idle();
    ex_mc_start = 1;
    next_cycle(); idle();
    excp_req = 1; excp_vector = 32'hBFC0_0380;
    push(0, "excp_mc", 6'b111111, 0, 32'h0, 0, 1, 0, 0, 16'h0);
    push(1, "excp_mc1", 6'b111111, 0, 32'h0, 0, 1, 0, 0, 16'h0);
    next_cycle(); idle();
    id_jump_en = 1;
    push(0, "flush", 6'b0, 1, 32'hBFC0_0380, 0, 0, 0, 0, 16'h0);
    next_cycle(); idle();
    id_jump_en = 1;
    push(0, "flush_end", 6'b0, 0, 32'h0, 1, 0, 0, 0, 16'h0);

    // Exception during FLUSH relatches and extends FLUSH
    next_cycle(); idle();
    excp_req = 1; excp_vector = 32'h8000_0180;
    push(0, "excp_run", 6'b111111, 0, 32'h0, 0, 0, 0, 0, 16'h0);
    next_cycle(); idle();
    excp_req = 1; excp_vector = 32'hBFC0_0200; id_jump_en = 1;
    push(0, "relatch", 6'b111111, 1, 32'h8000_0180, 0, 0, 0, 0, 16'h0);
    next_cycle(); idle();
    id_jump_en = 1;
    push(0, "flush2", 6'b0, 1, 32'hBFC0_0200, 0, 0, 0, 0, 16'h0);
    next_cycle(); idle();
    id_jump_en = 1;
    push(0, "flush2_end", 6'b0, 0, 32'h0, 1, 0, 0, 0, 16'h0);

    // Asynchronous reset in the middle of FLUSH
    next_cycle(); idle();
    excp_req = 1; excp_vector = 32'hDEAD_BEEF;
    next_cycle(); idle();
    id_jump_en = 1;
    push(0, "pre_rst", 6'b0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 16'h0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    e.cyc = cyc; e.name = "async_rst"; e.stall = 6'b0; e.flush = 0; e.fpc = 32'h0;
    e.jok = 0; e.abrt = 0; e.tmo = 0; e.chk_cnt = 1; e.cnt = 16'h0;
    e.dut = 0; check(e);
    e.dut = 1; check(e);
    next_cycle();
    rst = 1'b0;
    idle();
    id_jump_en = 1;
    push(0, "post_rst", 6'b0, 0, 32'h0, 1, 0, 0, 1, 16'h0);

    // Saturation with mem stall plus load-use
    next_cycle(); idle();
    mem_stallreq = 1; ex_is_load = 1; ex_waddr = 5; id_r1_en = 1; id_r1_addr = 5;
    for (int i = 0; i < 70000; i++) begin
      next_cycle();
    end
    push(0, "sat", 6'b011111, 0, 32'h0, 0, 0, 0, 1, 16'hFFFF);
    next_cycle();
    push(0, "sat_hold", 6'b011111, 0, 32'h0, 0, 0, 0, 1, 16'hFFFF);
    next_cycle(); idle();
    push(0, "sat_idle", 6'b0, 0, 32'h0, 0, 0, 0, 1, 16'hFFFF);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
